// File: rtl/seg_pkg.sv
// Shared display constants: digit ordering, segment width and the 0-9 glyph table
// used by both the RTC encoders and the scan multiplexer.
package seg_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NUM_DIGITS = 6;

   localparam int unsigned DIG_SEC_L = 0;
   localparam int unsigned DIG_SEC_M = 1;
   localparam int unsigned DIG_MIN_L = 2;
   localparam int unsigned DIG_MIN_M = 3;
   localparam int unsigned DIG_HR_L  = 4;
   localparam int unsigned DIG_HR_M  = 5;

   typedef logic [SEG_W-1:0] seg_t;

   // bit0=a .. bit6=g, active-high
   localparam seg_t SEG_0 = 7'h3F;
   localparam seg_t SEG_1 = 7'h06;
   localparam seg_t SEG_2 = 7'h5B;
   localparam seg_t SEG_3 = 7'h4F;
   localparam seg_t SEG_4 = 7'h66;
   localparam seg_t SEG_5 = 7'h6D;
   localparam seg_t SEG_6 = 7'h7D;
   localparam seg_t SEG_7 = 7'h07;
   localparam seg_t SEG_8 = 7'h7F;
   localparam seg_t SEG_9 = 7'h6F;

   function automatic seg_t seg_encode(input logic [3:0] d);
      seg_t s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Bundle between the RTC top (master) and the scan multiplexer (slave):
// six digit patterns, brightness and enable in; shared segment bus and digit enables out.
interface seg_scan_mux_if;
   import seg_pkg::*;

   logic                  en;
   seg_t                  sec_l;
   seg_t                  sec_m;
   seg_t                  min_l;
   seg_t                  min_m;
   seg_t                  hr_l;
   seg_t                  hr_m;
   logic [2:0]            bright;
   seg_t                  seg_out;
   logic [NUM_DIGITS-1:0] dig_en;
   logic                  frame_start;

   modport master (
      output en, sec_l, sec_m, min_l, min_m, hr_l, hr_m, bright,
      input  seg_out, dig_en, frame_start
   );

   modport slave (
      input  en, sec_l, sec_m, min_l, min_m, hr_l, hr_m, bright,
      output seg_out, dig_en, frame_start
   );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter (cnt) and digit index (idx) for the scan, plus the frame-end and
// frame-first strobes. Both counters sit at zero while the scan is disabled.
module seg_scan_timer #(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DIGITS   = 6,
   parameter int unsigned CNT_W    = $clog2(SCAN_DIV),
   parameter int unsigned IDX_W    = $clog2(DIGITS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic [IDX_W-1:0] idx,
   output logic             frame_wrap,
   output logic             frame_first
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             last_cnt, last_idx;

   assign last_cnt = (cnt_q == CNT_W'(SCAN_DIV - 1));
   assign last_idx = (idx_q == IDX_W'(DIGITS - 1));

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!en) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (last_cnt) begin
         cnt_d = '0;
         idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // frame_wrap: this edge moves the scan to (0,0); frame_first: the scan is at (0,0)
   assign frame_wrap  = en && last_cnt && last_idx;
   assign frame_first = en && (cnt_q == '0) && (idx_q == '0);
   assign cnt         = cnt_q;
   assign idx         = idx_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes six 7-segment patterns onto one shared bus with one-hot digit
// enables; per-frame snapshot of digits and brightness, slot-start blanking and 8-level PWM.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS    = NUM_DIGITS,
   parameter int unsigned SCAN_DIV  = 1000,
   parameter int unsigned BLANK_CYC = 8
) (
   input  logic clk,
   input  logic rst,
   seg_scan_mux_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = $clog2(DIGITS);
   localparam int unsigned UNIT  = (SCAN_DIV - BLANK_CYC) / 8;

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             frame_wrap, frame_first;

   seg_scan_timer #(
      .SCAN_DIV (SCAN_DIV),
      .DIGITS   (DIGITS),
      .CNT_W    (CNT_W),
      .IDX_W    (IDX_W)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .en          (bus.en),
      .cnt         (cnt),
      .idx         (idx),
      .frame_wrap  (frame_wrap),
      .frame_first (frame_first)
   );

   logic [DIGITS-1:0][SEG_W-1:0] dig_in;

   assign dig_in[DIG_SEC_L] = bus.sec_l;
   assign dig_in[DIG_SEC_M] = bus.sec_m;
   assign dig_in[DIG_MIN_L] = bus.min_l;
   assign dig_in[DIG_MIN_M] = bus.min_m;
   assign dig_in[DIG_HR_L]  = bus.hr_l;
   assign dig_in[DIG_HR_M]  = bus.hr_m;

   logic [DIGITS-1:0][SEG_W-1:0] shadow_q, shadow_d;
   logic [2:0]                   bright_s_q, bright_s_d;

   // Shadow tracks the inputs while idle and otherwise only refreshes on the frame wrap,
   // so a frame never mixes pre- and post-rollover digits.
   always_comb begin
      shadow_d   = shadow_q;
      bright_s_d = bright_s_q;
      if (!bus.en || frame_wrap) begin
         shadow_d   = dig_in;
         bright_s_d = bus.bright;
      end
   end

   logic [31:0] cnt_ext, on_len;
   logic        active;

   always_comb begin
      cnt_ext = 32'(cnt);
      on_len  = (32'(bright_s_q) + 32'd1) * 32'(UNIT);
      active  = (cnt_ext >= 32'(BLANK_CYC)) && (cnt_ext < 32'(BLANK_CYC) + on_len);
   end

   logic [SEG_W-1:0]  seg_q, seg_d;
   logic [DIGITS-1:0] dig_en_q, dig_en_d;
   logic              frame_start_q, frame_start_d;

   always_comb begin
      seg_d         = '0;
      dig_en_d      = '0;
      frame_start_d = frame_first;
      if (bus.en && active) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
               dig_en_d[i] = 1'b1;
               seg_d       = shadow_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q      <= '0;
         bright_s_q    <= '0;
         seg_q         <= '0;
         dig_en_q      <= '0;
         frame_start_q <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         bright_s_q    <= bright_s_d;
         seg_q         <= seg_d;
         dig_en_q      <= dig_en_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.seg_out     = seg_q;
   assign bus.dig_en      = dig_en_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with SCAN_DIV=18, BLANK_CYC=2 (UNIT=2, 108-cycle frame):
// timeline reference model, brightness/slot table and hand-built corner sequences.
module tb_seg_scan_mux;
   import seg_pkg::*;

   localparam int SD    = 18;
   localparam int BC    = 2;
   localparam int UNITC = (SD - BC) / 8;
   localparam int FRAME = SD * 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg_scan_mux_if bus();

   seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference: t counts enabled edges since the scan (re)started; slot and position
   // follow from plain division, and the snapshot refreshes once per FRAME.
   int         t;
   logic [6:0] snap [6];
   int         bs;

   typedef struct {
      int         bright;
      int         slot;
      logic [6:0] pat;
      int         exp_lead;
      int         exp_on;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] cur_in(input int i);
      case (i)
         0: return bus.sec_l;
         1: return bus.sec_m;
         2: return bus.min_l;
         3: return bus.min_m;
         4: return bus.hr_l;
         default: return bus.hr_m;
      endcase
   endfunction

   task automatic model_load();
      for (int i = 0; i < 6; i++) snap[i] = cur_in(i);
      bs = int'(bus.bright);
   endtask

   task automatic model_reset();
      t = 0;
      bs = 0;
      for (int i = 0; i < 6; i++) snap[i] = '0;
   endtask

   // One clock: predict the registered outputs from the current inputs, advance, compare.
   task automatic tick();
      logic [6:0] es;
      logic [5:0] ed;
      logic       ef;
      int         pos, slot;
      es = '0; ed = '0; ef = 1'b0;
      if (bus.en) begin
         pos  = t % SD;
         slot = (t / SD) % 6;
         if (pos >= BC && pos < BC + (bs + 1) * UNITC) begin
            ed = 6'(1 << slot);
            es = snap[slot];
         end
         ef = (t % FRAME == 0);
         if (t % FRAME == FRAME - 1) model_load();
         t++;
      end else begin
         model_load();
         t = 0;
      end
      @(posedge clk);
      #1;
      check("scan_model", 32'({bus.seg_out, bus.dig_en, bus.frame_start}), 32'({es, ed, ef}));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Runs one slot, reporting leading blank cycles, cycles showing the wanted digit, and frame_start on entry.
   task automatic run_slot(input logic [5:0] exp_dig, input logic [6:0] exp_seg,
                           output int lead, output int on_cnt, output logic fs_first);
      bit in_lead;
      lead = 0; on_cnt = 0; in_lead = 1'b1; fs_first = 1'b0;
      for (int i = 0; i < SD; i++) begin
         tick();
         if (i == 0) fs_first = bus.frame_start;
         if (in_lead && bus.dig_en == '0) lead++;
         else in_lead = 1'b0;
         if (bus.dig_en == exp_dig && bus.seg_out == exp_seg) on_cnt++;
      end
   endtask

   task automatic set_pats();
      bus.sec_l = 7'h3F; bus.sec_m = 7'h06; bus.min_l = 7'h5B;
      bus.min_m = 7'h4F; bus.hr_l  = 7'h66; bus.hr_m  = 7'h6D;
   endtask

   task automatic restart(input int br);
      bus.en = 1'b0;
      bus.bright = 3'(br);
      ticks(2);
      bus.en = 1'b1;
   endtask

   int         lead, on_cnt;
   logic       fs;

   initial begin
      vecs[0] = '{7, 0, 7'h3F, 2, 16};
      vecs[1] = '{7, 1, 7'h06, 2, 16};
      vecs[2] = '{7, 2, 7'h5B, 2, 16};
      vecs[3] = '{7, 3, 7'h4F, 2, 16};
      vecs[4] = '{7, 4, 7'h66, 2, 16};
      vecs[5] = '{7, 5, 7'h6D, 2, 16};
      vecs[6] = '{0, 0, 7'h3F, 2, 2};
      vecs[7] = '{3, 0, 7'h3F, 2, 8};
      vecs[8] = '{3, 4, 7'h66, 2, 8};

      rst = 1'b1;
      bus.en = 1'b0; bus.bright = '0;
      bus.sec_l = '0; bus.sec_m = '0; bus.min_l = '0;
      bus.min_m = '0; bus.hr_l = '0; bus.hr_m = '0;
      model_reset();
      #12;
      check("reset_outputs", 32'({bus.seg_out, bus.dig_en, bus.frame_start}), 32'd0);
      rst = 1'b0;

      // idle with en=0
      ticks(20);

      // brightness / slot table
      set_pats();
      foreach (vecs[k]) begin
         restart(vecs[k].bright);
         ticks(vecs[k].slot * SD);
         run_slot(6'(1 << vecs[k].slot), vecs[k].pat, lead, on_cnt, fs);
         check($sformatf("tbl%0d_lead", k), 32'(lead), 32'(vecs[k].exp_lead));
         check($sformatf("tbl%0d_on", k), 32'(on_cnt), 32'(vecs[k].exp_on));
      end

      // frame_start spacing at full brightness
      restart(7);
      run_slot(6'b000001, 7'h3F, lead, on_cnt, fs);
      check("fs_first_frame", 32'(fs), 32'd1);
      ticks(FRAME - SD);
      run_slot(6'b000001, 7'h3F, lead, on_cnt, fs);
      check("fs_second_frame", 32'(fs), 32'd1);

      // snapshot: sec_l and bright change mid-frame apply only at the next frame
      restart(7);
      ticks(2 * SD + 5);
      bus.sec_l = 7'h06;
      bus.bright = 3'd0;
      ticks(SD - 5);
      run_slot(6'b001000, 7'h4F, lead, on_cnt, fs);
      check("snap_bright_hold", 32'(on_cnt), 32'd16);
      ticks(2 * SD);
      run_slot(6'b000001, 7'h06, lead, on_cnt, fs);
      check("snap_new_digit", 32'(on_cnt), 32'd2);
      check("snap_new_frame_fs", 32'(fs), 32'd1);

      // en drop during idx 3, then restart with fresh inputs
      restart(7);
      ticks(3 * SD + 6);
      check("drop_pre_dig", 32'(bus.dig_en), 32'b001000);
      bus.en = 1'b0;
      tick();
      check("drop_dig_off", 32'(bus.dig_en), 32'd0);
      bus.sec_l = 7'h5B;
      tick();
      bus.en = 1'b1;
      run_slot(6'b000001, 7'h5B, lead, on_cnt, fs);
      check("restart_fs", 32'(fs), 32'd1);
      check("restart_on", 32'(on_cnt), 32'd16);

      // async reset between edges while digit 4 is lit
      set_pats();
      restart(7);
      ticks(4 * SD + 5);
      check("arst_pre_dig", 32'(bus.dig_en), 32'b010000);
      #2;
      rst = 1'b1;
      #1;
      check("arst_dig_zero", 32'(bus.dig_en), 32'd0);
      check("arst_seg_zero", 32'(bus.seg_out), 32'd0);
      model_reset();
      #2;
      rst = 1'b0;
      run_slot(6'b000001, 7'h00, lead, on_cnt, fs);
      check("arst_restart_fs", 32'(fs), 32'd1);
      ticks(FRAME - SD);
      run_slot(6'b000001, 7'h3F, lead, on_cnt, fs);
      check("arst_next_frame_on", 32'(on_cnt), 32'd16);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 5))
               0: bus.sec_l = 7'($urandom);
               1: bus.sec_m = 7'($urandom);
               2: bus.min_l = 7'($urandom);
               3: bus.min_m = 7'($urandom);
               4: bus.hr_l  = 7'($urandom);
               default: bus.hr_m = 7'($urandom);
            endcase
         end
         if ($urandom_range(0, 49) == 0) bus.bright = 3'($urandom);
         if ($urandom_range(0, 199) == 0) bus.en = ~bus.en;
         else if (!bus.en && $urandom_range(0, 9) == 0) bus.en = 1'b1;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Consumer end of the real-time clock's six 7-segment digit outputs. It time-multiplexes the six segment patterns onto one shared segment bus with one-hot digit enables, suitable for a common-cathode multiplexed display. Each frame uses a snapshot of all digits, so a display frame never tears while the clock is rolling over. It also provides anti-ghost blanking and 8-level PWM brightness. It sits between the RTC top and the board pins.

Parameters:
DIGITS, 6, number of multiplexed digits (fixed at 6 for the RTC).
SCAN_DIV, 1000, clock cycles per digit slot.
BLANK_CYC, 8, cycles at the start of each slot with digits forced off. (SCAN_DIV-BLANK_CYC) must be divisible by 8.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
en  input  1  scan enable
sec_l  input  7  seconds units pattern, bit0=a .. bit6=g, active-high
sec_m  input  7  seconds tens pattern
min_l  input  7  minutes units pattern
min_m  input  7  minutes tens pattern
hr_l  input  7  hours units pattern
hr_m  input  7  hours tens pattern
bright  input  3  brightness level, 0=dimmest (1/8), 7=full
seg_out  output  7  shared segment bus
dig_en  output  6  one-hot digit enable; bit0=sec_l .. bit5=hr_m
frame_start  output  1  one-cycle pulse at the start of each frame

Behaviour:
- State: cnt (0..SCAN_DIV-1) and idx (0..DIGITS-1). Shadow: six 7-bit digit registers plus a 3-bit bright_s register.
- Reset (asynchronous): cnt=0, idx=0, shadow=0, bright_s=0, seg_out=0, dig_en=0, frame_start=0.
- en=0:
  - cnt and idx are held at 0.
  - Shadow and bright_s load the inputs every cycle (transparent tracking).
  - Outputs are registered to 0 on the next edge.
- en=1, each edge:
  - cnt increments.
  - When cnt==SCAN_DIV-1: cnt wraps to 0 and idx increments, wrapping from DIGITS-1 to 0.
  - When idx==DIGITS-1 and cnt==SCAN_DIV-1 (the next state is (0,0)), shadow and bright_s load the inputs. They hold at every other enabled edge.
- Digit on-window:
  - UNIT=(SCAN_DIV-BLANK_CYC)/8.
  - on_len=(bright_s+1)*UNIT, computed with enough width for SCAN_DIV with no truncation.
  - active = (cnt>=BLANK_CYC) and (cnt<BLANK_CYC+on_len).
- Outputs are registered with 1-cycle latency behind state (idx,cnt):
  - dig_en = active ? (1<<idx) : 0.
  - seg_out = active ? shadow[idx] : 0.
  - frame_start = 1 in the cycle after state (0,0) was present with en=1.
- At most one dig_en bit is ever high. seg_out is 0 whenever dig_en is 0.
- Input changes mid-frame do not affect the display until the next frame boundary. A change to bright also takes effect only at the frame boundary.
- en falling mid-frame: the scan aborts and outputs go to 0 one cycle later. en rising restarts at idx=0 using the tracked shadow.
- Reset mid-frame: immediate return to reset values, independent of clk.
- bright=7 with BLANK_CYC=0: dig_en for the current digit is continuous for the whole slot.

Decomposition:
- Shared package seg_pkg:
  - SEG_W=7
  - NUM_DIGITS=6
  - digit index constants DIG_SEC_L=0 .. DIG_HR_M=5
  - segment patterns for 0-9, shared with the RTC encoders.
- One sub-module, seg_scan_timer: cnt/idx counters, wrap logic, and the frame-boundary strobe.
- The top level holds the shadow registers, the on-window compare and the output registers.

Test Plan (override SCAN_DIV=18, BLANK_CYC=2, so UNIT=2; a frame is 108 cycles):
- Reset/idle: rst=1, then rst=0 with en=0 for 20 cycles -> seg_out=0, dig_en=0, frame_start=0 throughout.
- Full-brightness scan: sec_l=7'h3F, sec_m=7'h06, min_l=7'h5B, min_m=7'h4F, hr_l=7'h66, hr_m=7'h6D, bright=7, en=1 -> per slot, dig_en=0 for 2 cycles then one-hot for 16 cycles. Order is 000001 .. 100000 carrying the matching pattern. frame_start pulses every 108 cycles.
- PWM: bright=0 -> each slot shows 2 blank cycles, 2 on cycles, 14 off cycles. bright=3 -> 2 blank, 8 on, 8 off.
- Snapshot: change sec_l from 7'h3F to 7'h06 while idx=2 -> seg_out for digit 0 stays 7'h3F for the rest of the frame and becomes 7'h06 in the next frame. A bright change mid-frame applies only from the next frame_start.
- en drop/restart: en=0 during idx=3 -> dig_en=0 one cycle later. en=1 -> next active digit is idx 0 with the current inputs, and frame_start pulses.
- Async reset mid-scan: rst pulse between clock edges while dig_en=6'b010000 -> dig_en and seg_out are 0 immediately. After release, the scan restarts at idx 0.
